// File: rtl/serial_add_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// serial_add_pkg: shared types and defaults for the serial add sequencer.
//   state_e       - controller state encoding (IDLE, RUN, DONE)
//   DEFAULT_WIDTH - default operand/result width in bits
// -----------------------------------------------------------------------------
package serial_add_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage : serial_add_pkg

// File: rtl/serial_add_sequencer_if.sv
// -----------------------------------------------------------------------------
// serial_add_sequencer_if: request/result handshake plus the bit-serial link
// to an external one_bit_adder.
//   Request : start, op_a, op_b, cin_init
//   Result  : busy, done, result, carry_out, err
//   Adder   : add_a, add_b, add_cin (to adder), add_sum, add_cout (from adder)
// Modports:
//   master - feeder/consumer side (drives request, hosts the adder)
//   slave  - the sequencer
// -----------------------------------------------------------------------------
interface serial_add_sequencer_if #(
  parameter int unsigned WIDTH = serial_add_pkg::DEFAULT_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             cin_init;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             carry_out;
  logic             err;
  logic             add_a;
  logic             add_b;
  logic             add_cin;
  logic             add_sum;
  logic             add_cout;

  modport master (
    output start, op_a, op_b, cin_init, add_sum, add_cout,
    input  busy, done, result, carry_out, err, add_a, add_b, add_cin
  );

  modport slave (
    input  start, op_a, op_b, cin_init, add_sum, add_cout,
    output busy, done, result, carry_out, err, add_a, add_b, add_cin
  );

endinterface : serial_add_sequencer_if

// File: rtl/serial_add_sequencer_checker.sv
// -----------------------------------------------------------------------------
// serial_add_checker: reference full-adder compare against the external adder
// with a sticky error flag. Only instantiated when SERIAL_ADD_CHECK_EN is set.
//   clk, rst_n       - clock, async active-low reset
//   i_run            - sequencer is in RUN (adder outputs are meaningful)
//   i_clr            - accepted start; clears the sticky flag
//   i_add_a/b/cin    - bits presented to the adder
//   i_add_sum/cout   - bits returned by the adder
//   o_err            - sticky mismatch flag
// -----------------------------------------------------------------------------
module serial_add_checker (
  input  logic clk,
  input  logic rst_n,
  input  logic i_run,
  input  logic i_clr,
  input  logic i_add_a,
  input  logic i_add_b,
  input  logic i_add_cin,
  input  logic i_add_sum,
  input  logic i_add_cout,
  output logic o_err
);

  logic w_sum_ref;
  logic w_cout_ref;
  logic w_mismatch;
  logic r_err;

  assign w_sum_ref  = i_add_a ^ i_add_b ^ i_add_cin;
  assign w_cout_ref = (i_add_a & i_add_b) | (i_add_a & i_add_cin) | (i_add_b & i_add_cin);
  assign w_mismatch = i_run & ((i_add_sum != w_sum_ref) | (i_add_cout != w_cout_ref));

  // Sticky until reset or the next accepted start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (i_clr) begin
      r_err <= 1'b0;
    end else if (w_mismatch) begin
      r_err <= 1'b1;
    end
  end

  assign o_err = r_err;

endmodule : serial_add_checker

// File: rtl/serial_add_sequencer.sv
// -----------------------------------------------------------------------------
// serial_add_sequencer: bit-serial controller wrapped around an external
// one_bit_adder. Captures two WIDTH-bit operands and a carry-in on start,
// feeds the adder LSB-first one bit per cycle, loops cout back into cin and
// shifts returned sum bits into result.
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset
//   bus    - serial_add_sequencer_if.slave (request, result, adder link)
// Optional: define SERIAL_ADD_CHECK_EN to add an adder self-check driving
// bus.err; otherwise bus.err is tied low.
// -----------------------------------------------------------------------------
module serial_add_sequencer
  import serial_add_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  serial_add_sequencer_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  state_e           r_state;
  state_e           w_next;
  logic [WIDTH-1:0] r_sh_a;
  logic [WIDTH-1:0] r_sh_b;
  logic [WIDTH-1:0] r_result;
  logic [CNT_W-1:0] r_cnt;
  logic             r_carry_q;
  logic             r_carry_out;
  logic             r_busy;
  logic             r_done;
  logic             w_start_acc;
  logic             w_run;
  logic             w_last;

  assign w_run       = (r_state == RUN);
  assign w_start_acc = (r_state == IDLE) & bus.start;
  assign w_last      = w_run & (r_cnt == CNT_W'(WIDTH - 1));

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (bus.start) w_next = RUN;
      RUN:     if (w_last)    w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // State register; busy/done registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_busy  <= (w_next == RUN);
      r_done  <= (w_next == DONE);
    end
  end

  // Operand capture, serial shift and result assembly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sh_a      <= '0;
      r_sh_b      <= '0;
      r_result    <= '0;
      r_cnt       <= '0;
      r_carry_q   <= 1'b0;
      r_carry_out <= 1'b0;
    end else if (w_start_acc) begin
      r_sh_a      <= bus.op_a;
      r_sh_b      <= bus.op_b;
      r_carry_q   <= bus.cin_init;
      r_cnt       <= '0;
      r_result    <= '0;
      r_carry_out <= 1'b0;
    end else if (w_run) begin
      r_result  <= {bus.add_sum, r_result[WIDTH-1:1]};
      r_carry_q <= bus.add_cout;
      r_sh_a    <= {1'b0, r_sh_a[WIDTH-1:1]};
      r_sh_b    <= {1'b0, r_sh_b[WIDTH-1:1]};
      r_cnt     <= r_cnt + CNT_W'(1);
      if (w_last) begin
        r_carry_out <= bus.add_cout;
      end
    end
  end

  // Adder inputs come straight from registers, gated to RUN.
  assign bus.add_a     = w_run & r_sh_a[0];
  assign bus.add_b     = w_run & r_sh_b[0];
  assign bus.add_cin   = w_run & r_carry_q;

  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.result    = r_result;
  assign bus.carry_out = r_carry_out;

`ifdef SERIAL_ADD_CHECK_EN
  serial_add_checker u_checker (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_run      (w_run),
    .i_clr      (w_start_acc),
    .i_add_a    (bus.add_a),
    .i_add_b    (bus.add_b),
    .i_add_cin  (bus.add_cin),
    .i_add_sum  (bus.add_sum),
    .i_add_cout (bus.add_cout),
    .o_err      (bus.err)
  );
`else
  assign bus.err = 1'b0;
`endif

endmodule : serial_add_sequencer

// File: doc/serial_add_sequencer.md
Name: serial_add_sequencer

Overview:
- Bit-serial controller that sits directly around one_bit_adder: the upstream feeder and the downstream consumer.
- Accepts two WIDTH-bit operands and a carry-in.
- Presents operand bits LSB-first to the adder's a/b/cin inputs, one bit per cycle.
- Registers the adder's cout back into cin, and assembles the returned sum bits into a WIDTH-bit result with start/busy/done handshake.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.
- CNT_W, $clog2(WIDTH+1), bit-counter width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request pulse; sampled only in IDLE.
- op_a  input  WIDTH  operand A; captured on accepted start.
- op_b  input  WIDTH  operand B; captured on accepted start.
- cin_init  input  1  initial carry; captured on accepted start.
- busy  output  1  high in RUN.
- done  output  1  one-cycle pulse in DONE.
- result  output  WIDTH  assembled sum; held until next accepted start.
- carry_out  output  1  final carry; held with result.
- add_a  output  1  to adder a.
- add_b  output  1  to adder b.
- add_cin  output  1  to adder cin.
- add_sum  input  1  from adder sum.
- add_cout  input  1  from adder cout.
- err  output  1  sticky self-check error; see Optional Feature.

Behaviour:
- Reset: clk is the only clock; rst_n is asynchronous and active-low. While rst_n=0, state=IDLE and busy, done, result, carry_out, err, the shift registers, carry_q and the counter are all 0.
- States: IDLE, RUN, DONE; one-hot or binary encoding is free.
- IDLE:
  - start=1 latches sh_a<=op_a, sh_b<=op_b, carry_q<=cin_init, cnt<=0, result<=0, carry_out<=0.
  - Next state is RUN.
  - start=0 stays in IDLE.
- RUN:
  - add_a=sh_a[0], add_b=sh_b[0], add_cin=carry_q, driven combinationally from registers. Outside RUN these outputs are 0.
  - Each edge: result<={add_sum, result[WIDTH-1:1]}; carry_q<=add_cout; sh_a and sh_b shift right with 0 fill; cnt<=cnt+1.
  - On the edge where cnt==WIDTH-1: carry_out<=add_cout, next state is DONE.
- DONE: done=1 for exactly one cycle, then unconditional move to IDLE. start in DONE is ignored.
- start while busy is ignored; operands are not re-captured.
- Latency:
  - start sampled at edge k gives busy=1 for cycles k+1..k+WIDTH.
  - done=1 in cycle k+WIDTH+1.
  - Throughput is one add per WIDTH+2 cycles.
- Arithmetic: {carry_out, result} = op_a + op_b + cin_init, modulo 2^(WIDTH+1). No overflow flag.
- Reset mid-RUN aborts immediately. No done pulse; result and carry_out read 0.
- op_a/op_b changes after capture have no effect.

Optional Feature:
- Macro: SERIAL_ADD_CHECK_EN.
- Defined: each RUN cycle, compare add_sum against add_a^add_b^add_cin and add_cout against the majority of the three.
  - Any mismatch sets err=1 at the next edge.
  - err is sticky; cleared only by rst_n or by an accepted start.
  - Purpose: detect a tampered or faulty adder.
- Undefined: err tied to 0; no checker logic.

Decomposition:
- Package serial_add_pkg holds:
  - state enum {IDLE, RUN, DONE};
  - a localparam for the default WIDTH.
- Natural sub-module: serial_add_checker, the reference compare plus sticky err flop. Instantiate it only under SERIAL_ADD_CHECK_EN.
- one_bit_adder is instantiated by the bench or parent, not inside this block.

Test Plan (bench uses a golden one_bit_adder unless stated):
- WIDTH=8, op_a=0x5A, op_b=0x3C, cin_init=0, start pulse -> busy for 8 cycles; done in cycle 9 after start; result=0x96, carry_out=0.
- op_a=0xFF, op_b=0x01, cin_init=0 -> result=0x00, carry_out=1. Then op_a=0xFF, op_b=0xFF, cin_init=1 -> result=0xFF, carry_out=1.
- Start 0x10+0x20; at busy cycle 3, pulse start with 0xAA/0x55 -> ignored. Result=0x30, single done pulse.
- Start any add; assert rst_n=0 at busy cycle 4 -> all outputs 0 immediately. No done pulse; the next start works normally.
- With SERIAL_ADD_CHECK_EN defined: adder model drives sum inverted in bit 2 -> err=1 from the following edge, held through DONE/IDLE; the next start clears it. With the macro undefined, the same stimulus gives err=0.
